// File: rtl/sme_feeder_if.sv
// Byte-stream input and engine-side load bus of the string-matching feeder.
// The master drives the stream and the result strobe, and the slave (the feeder) drives the rest.
interface sme_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_kind;
    logic       in_last;
    logic [7:0] in_data;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       busy;
    logic       err;

    modport master (
        output in_valid, in_kind, in_last, in_data, sme_valid,
        input  in_ready, chardata, isstring, ispattern, busy, err
    );

    modport slave (
        input  in_valid, in_kind, in_last, in_data, sme_valid,
        output in_ready, chardata, isstring, ispattern, busy, err
    );
endinterface

// File: rtl/sme_feeder.sv
// Buffers one string and one pattern record from a tagged byte stream and replays them
// to the matching engine as back-to-back isstring/ispattern bursts, then waits for its result.
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    sme_feeder_if.slave bus
);

    localparam int SW  = $clog2(STR_MAX) + 1;
    localparam int PW  = $clog2(PAT_MAX) + 1;
    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int IW  = (SW > PW) ? SW : PW;

    localparam logic [SW-1:0] SMAX = SW'(STR_MAX);
    localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PLAY_S,
        PLAY_P,
        GAP,
        WAIT
    } state_t;

    state_t        state;
    logic          cur_kind;
    logic [SW-1:0] slen;
    logic [PW-1:0] plen;
    logic [IW-1:0] idx;
    logic          str_new;

    logic [7:0]    chardata_q;
    logic          isstring_q;
    logic          ispattern_q;
    logic          in_ready_q;
    logic          busy_q;
    logic          err_q;

    logic [7:0]    strbuf [STR_MAX];
    logic [7:0]    patbuf [PAT_MAX];

    logic          accept;
    logic          first;
    logic          kind;
    logic [SW-1:0] s_wr;
    logic [PW-1:0] p_wr;
    logic          s_room;
    logic          p_room;
    logic          s_wen;
    logic          p_wen;
    logic [7:0]    pat_first;

    assign bus.chardata  = chardata_q;
    assign bus.isstring  = isstring_q;
    assign bus.ispattern = ispattern_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

    // The first byte of a record restarts its kind's length, so the write slot is 0 then.
    assign accept = bus.in_valid & in_ready_q;
    assign first  = (state == IDLE);
    assign kind   = first ? bus.in_kind : cur_kind;
    assign s_wr   = first ? '0 : slen;
    assign p_wr   = first ? '0 : plen;
    assign s_room = (s_wr < SMAX);
    assign p_room = (p_wr < PMAX);
    assign s_wen  = accept & ~kind & s_room;
    assign p_wen  = accept & kind & p_room;

    // A one-byte pattern is still being written when playout starts, so forward it.
    assign pat_first = (p_wr == '0) ? bus.in_data : patbuf[0];

    // Buffer contents deliberately survive reset; only the lengths are cleared.
    always_ff @(posedge clk) begin
        if (s_wen) begin
            strbuf[s_wr[SAW-1:0]] <= bus.in_data;
        end
        if (p_wen) begin
            patbuf[p_wr[PAW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_kind    <= 1'b0;
            slen        <= '0;
            plen        <= '0;
            idx         <= '0;
            str_new     <= 1'b0;
            chardata_q  <= 8'h00;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        cur_kind <= kind;
                        if (!kind) begin
                            slen <= s_room ? s_wr + SW'(1) : s_wr;
                        end else begin
                            plen <= p_room ? p_wr + PW'(1) : p_wr;
                        end
                        if (kind ? !p_room : !s_room) begin
                            err_q <= 1'b1;
                        end
                        if (!bus.in_last) begin
                            state <= FILL;
                        end else if (!kind) begin
                            str_new <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            idx        <= IW'(1);
                            if (str_new) begin
                                state      <= PLAY_S;
                                chardata_q <= strbuf[0];
                                isstring_q <= 1'b1;
                            end else begin
                                state       <= PLAY_P;
                                chardata_q  <= pat_first;
                                ispattern_q <= 1'b1;
                            end
                        end
                    end
                end

                // idx always points at the next byte to present; byte 0 went out on entry.
                PLAY_S: begin
                    if (idx < IW'(slen)) begin
                        chardata_q <= strbuf[idx[SAW-1:0]];
                        idx        <= idx + IW'(1);
                    end else begin
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b1;
                        chardata_q  <= patbuf[0];
                        idx         <= IW'(1);
                        str_new     <= 1'b0;
                        state       <= PLAY_P;
                    end
                end

                PLAY_P: begin
                    if (idx < IW'(plen)) begin
                        chardata_q <= patbuf[idx[PAW-1:0]];
                        idx        <= idx + IW'(1);
                    end else begin
                        ispattern_q <= 1'b0;
                        state       <= GAP;
                    end
                end

                GAP: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.sme_valid) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: sends string/pattern records and checks the replayed
// engine bursts, gap, result handshake, overflow flag and mid-playout reset.
module tb_sme_feeder;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sme_feeder_if bus();

    sme_feeder #(.STR_MAX(32), .PAT_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic applyStimulus(input logic kind, input logic last, input logic [7:0] data);
        checkOutput("in_ready_before_byte", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_last  = last;
        bus.in_data  = data;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic sendRecord(input logic kind, input bq_t q);
        for (int i = 0; i < q.size(); i++) applyStimulus(kind, (i == q.size() - 1), q[i]);
    endtask

    // Called in the cycle after the pattern's last byte was accepted.
    task automatic expectBurst(input bq_t s, input bq_t p);
        for (int i = 0; i < s.size(); i++) begin
            checkOutput($sformatf("str[%0d]", i),
                        32'({bus.isstring, bus.ispattern, bus.busy, bus.in_ready, bus.chardata}),
                        32'({1'b1, 1'b0, 1'b1, 1'b0, s[i]}));
            step();
        end
        for (int i = 0; i < p.size(); i++) begin
            checkOutput($sformatf("pat[%0d]", i),
                        32'({bus.isstring, bus.ispattern, bus.busy, bus.in_ready, bus.chardata}),
                        32'({1'b0, 1'b1, 1'b1, 1'b0, p[i]}));
            step();
        end
        checkOutput("gap", 32'({bus.isstring, bus.ispattern, bus.busy, bus.in_ready, bus.chardata}),
                    32'({4'b0010, p[p.size() - 1]}));
        step();
        checkOutput("wait", 32'({bus.isstring, bus.ispattern, bus.busy, bus.in_ready}), 32'h2);
    endtask

    task automatic releaseEngine();
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("wait_hold", 32'({bus.busy, bus.in_ready}), 32'h2);
        end
        bus.sme_valid = 1'b1;
        step();
        bus.sme_valid = 1'b0;
        checkOutput("release", 32'({bus.busy, bus.in_ready}), 32'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bq_t none;
        bq_t long_str;

        bus.in_valid  = 1'b0;
        bus.in_kind   = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = 8'h00;
        bus.sme_valid = 1'b0;
        reset         = 1'b1;
        step();
        step();
        checkOutput("reset_state",
                    32'({bus.in_ready, bus.busy, bus.err, bus.isstring, bus.ispattern, bus.chardata}),
                    32'({5'b10000, 8'h00}));
        reset = 1'b0;
        step();

        $display("[TB] string + pattern");
        sendRecord(1'b0, str2q("ab ca"));
        sendRecord(1'b1, str2q("^ca"));
        expectBurst(str2q("ab ca"), str2q("^ca"));
        releaseEngine();

        $display("[TB] pattern without new string");
        sendRecord(1'b1, str2q("a$"));
        expectBurst(none, str2q("a$"));
        releaseEngine();

        $display("[TB] latest string wins");
        sendRecord(1'b0, str2q("xx"));
        sendRecord(1'b0, str2q("yyy"));
        sendRecord(1'b1, str2q("y"));
        expectBurst(str2q("yyy"), str2q("y"));
        releaseEngine();

        $display("[TB] string overflow");
        for (int i = 0; i < 34; i++) begin
            applyStimulus(1'b0, (i == 33), 8'(8'h40 + i));
            if (i == 31) checkOutput("err_at_32", 32'(bus.err), 32'd0);
            if (i == 32) checkOutput("err_at_33", 32'(bus.err), 32'd1);
        end
        for (int i = 0; i < 32; i++) long_str.push_back(8'(8'h40 + i));
        sendRecord(1'b1, str2q("A"));
        expectBurst(long_str, str2q("A"));
        releaseEngine();
        checkOutput("err_sticky", 32'(bus.err), 32'd1);

        $display("[TB] sme_valid during pattern playout");
        sendRecord(1'b1, str2q("ab"));
        checkOutput("p5_0", 32'({bus.isstring, bus.ispattern, bus.chardata}), 32'({2'b01, 8'h61}));
        bus.sme_valid = 1'b1;
        step();
        bus.sme_valid = 1'b0;
        checkOutput("p5_1", 32'({bus.isstring, bus.ispattern, bus.chardata}), 32'({2'b01, 8'h62}));
        step();
        checkOutput("p5_gap", 32'({bus.isstring, bus.ispattern, bus.busy}), 32'h1);
        step();
        checkOutput("p5_wait", 32'({bus.busy, bus.in_ready}), 32'h2);
        releaseEngine();

        $display("[TB] reset during string playout");
        sendRecord(1'b0, str2q("hello"));
        sendRecord(1'b1, str2q("h"));
        checkOutput("r6_0", 32'({bus.isstring, bus.chardata}), 32'({1'b1, 8'h68}));
        step();
        checkOutput("r6_1", 32'({bus.isstring, bus.chardata}), 32'({1'b1, 8'h65}));
        reset = 1'b1;
        #1;
        checkOutput("r6_async",
                    32'({bus.isstring, bus.ispattern, bus.busy, bus.in_ready, bus.err}),
                    32'b00010);
        step();
        reset = 1'b0;
        sendRecord(1'b1, str2q("z"));
        expectBurst(none, str2q("z"));
        releaseEngine();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
